// File: rtl/frogger_level_controller_pkg.sv
// -----------------------------------------------------------------------------
// frogger_level_controller_pkg
// Shared definitions for the Frogger level sequencer and its scroll prescaler:
//   - flc_state_e       : level-sequencer state encoding
//   - STROBE_ACTIVE/IDLE: polarity of the active-low player-FSM strobes
//   - WAIT_ACK_TIMEOUT  : clocks without a player-FSM ack before PlayerLose is re-sent
//   - scroll_period()   : scroll-tick period for a given level (never below 1)
// -----------------------------------------------------------------------------
package frogger_level_controller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_RUN      = 4'd2,
    ST_HIT      = 4'd3,
    ST_LEVELUP  = 4'd4,
    ST_WAIT_ACK = 4'd5,
    ST_RESPAWN  = 4'd6,
    ST_RELOAD   = 4'd7,
    ST_GAMEOVER = 4'd8,
    ST_WIN      = 4'd9
  } flc_state_e;

  // PlayerLose / FinishedLevel are active-low strobes into the player FSM.
  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;

  localparam int unsigned WAIT_ACK_TIMEOUT = 16;
  localparam int unsigned TMO_W            = $clog2(WAIT_ACK_TIMEOUT);

  // Period halves with every level; clamp so a deep level never yields 0.
  function automatic int unsigned scroll_period(input int unsigned base,
                                                input logic [1:0]  lvl);
    int unsigned p;
    p = base >> lvl;
    if (p == 32'd0) begin
      p = 32'd1;
    end else begin
      p = p;
    end
    return p;
  endfunction

endpackage

// File: rtl/frogger_tick_prescaler.sv
// -----------------------------------------------------------------------------
// frogger_tick_prescaler
// Generates the one-cycle obstacle-scroll enable. The counter runs 0..P-1 with
// P = BASE_PERIOD >> level (minimum 1) and the tick is high in the cycle the
// counter sits at P-1, i.e. the cycle in which it wraps.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   level_i [1:0]  : level valid in the coming cycle
//   enable_i       : the coming cycle is a counting (RUN) cycle
//   clear_i        : restart the count from 0 for the coming cycle
//   scroll_tick_o  : registered one-cycle scroll enable
// -----------------------------------------------------------------------------
module frogger_tick_prescaler
  import frogger_level_controller_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] level_i,
  input  logic       enable_i,
  input  logic       clear_i,
  output logic       scroll_tick_o
);

  localparam int unsigned CNT_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] last_s;
  logic             tick_q;
  logic             tick_d;
  int unsigned      period_s;

  // Terminal count for the level that applies to the coming cycle.
  always_comb begin
    period_s = scroll_period(BASE_PERIOD, level_i);
    last_s   = CNT_W'(period_s - 32'd1);
  end

  // Next count, and a look-ahead so the tick register lines up with the
  // cycle whose count value is the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q >= last_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    tick_d = enable_i && (cnt_d == last_s);
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign scroll_tick_o = tick_q;

endmodule

// File: rtl/frogger_level_controller.sv
// -----------------------------------------------------------------------------
// frogger_level_controller
// Game-level sequencer in front of the player state machine. Detects collisions
// between the player row and the active obstacle row, tracks lives and level,
// and drives the active-low PlayerLose / FinishedLevel strobes that walk the
// player FSM through its lose -> load-player sequence. Owns the level-dependent
// obstacle scroll tick through frogger_tick_prescaler.
// Ports:
//   SC_PLAYER_STATEMACHINE_CLOCK_50      : system clock
//   SC_PLAYER_STATEMACHINE_RESET_InHigh  : asynchronous active-high reset
//   start_InLow           : start button (synchronised, debounced)
//   player_row [7:0]      : one-hot player position (0 = row not loaded)
//   obstacle_row [7:0]    : obstacles on the player's row
//   goal_InLow            : low when the player reached the goal row
//   player_lose_ack_InLow : player FSM is in its lose state (low)
//   PlayerLose_OutLow     : one-cycle low strobe to the player FSM
//   FinishedLevel_OutLow  : one-cycle low strobe to the player FSM
//   scroll_tick           : one-cycle obstacle-shift enable
//   level [1:0], lives [1:0], game_over, game_won : status to the display
// All outputs are registered. Strobes are decoded from the next state so that
// each is low exactly during the cycle the FSM spends in the strobing state.
// -----------------------------------------------------------------------------
module frogger_level_controller
  import frogger_level_controller_pkg::*;
#(
  parameter int unsigned BASE_PERIOD  = 24,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned MAX_LEVEL    = 3,
  parameter int unsigned RESPAWN_HOLD = 8
) (
  input  logic       SC_PLAYER_STATEMACHINE_CLOCK_50,
  input  logic       SC_PLAYER_STATEMACHINE_RESET_InHigh,
  input  logic       start_InLow,
  input  logic [7:0] player_row,
  input  logic [7:0] obstacle_row,
  input  logic       goal_InLow,
  input  logic       player_lose_ack_InLow,
  output logic       PlayerLose_OutLow,
  output logic       FinishedLevel_OutLow,
  output logic       scroll_tick,
  output logic [1:0] level,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       game_won
);

  localparam logic [1:0]       LEVEL_MAX  = 2'(MAX_LEVEL);
  localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);
  localparam int unsigned      HOLD_W     = $clog2(RESPAWN_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESPAWN_HOLD - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(WAIT_ACK_TIMEOUT - 1);

  flc_state_e        state_q;
  flc_state_e        state_d;
  logic [1:0]        level_q;
  logic [1:0]        level_d;
  logic [1:0]        lives_q;
  logic [1:0]        lives_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tmo_d;
  logic              pl_q;
  logic              pl_d;
  logic              fl_q;
  logic              fl_d;
  logic              over_q;
  logic              over_d;
  logic              won_q;
  logic              won_d;

  logic              hit_s;
  logic              run_next_s;
  logic              run_clear_s;

  // An unloaded player row (all zero) can never collide.
  assign hit_s = |(player_row & obstacle_row);

  // Next-state, counter and strobe decode for the level sequencer.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    pl_d    = STROBE_IDLE;
    fl_d    = STROBE_IDLE;

    unique case (state_q)
      ST_IDLE: begin
        if (!start_InLow) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        lives_d = LIVES_INIT;
        level_d = 2'd0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // A collision wins over reaching the goal in the same cycle.
        if (hit_s) begin
          state_d = ST_HIT;
          pl_d    = STROBE_ACTIVE;
        end else if (!goal_InLow) begin
          state_d = ST_LEVELUP;
          // The final level ends in WIN and leaves the player FSM alone.
          if (level_q != LEVEL_MAX) begin
            pl_d = STROBE_ACTIVE;
          end else begin
            pl_d = STROBE_IDLE;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_HIT: begin
        if (lives_q != 2'd0) begin
          lives_d = lives_q - 2'd1;
        end else begin
          lives_d = lives_q;
        end
        tmo_d   = {TMO_W{1'b0}};
        state_d = ST_WAIT_ACK;
      end

      ST_LEVELUP: begin
        if (level_q == LEVEL_MAX) begin
          state_d = ST_WIN;
        end else begin
          level_d = level_q + 2'd1;
          tmo_d   = {TMO_W{1'b0}};
          state_d = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        if (!player_lose_ack_InLow) begin
          hold_d  = {HOLD_W{1'b0}};
          tmo_d   = {TMO_W{1'b0}};
          state_d = ST_RESPAWN;
        end else if (tmo_q == TMO_LAST) begin
          // The player FSM missed the strobe: send it again and re-arm.
          tmo_d = {TMO_W{1'b0}};
          pl_d  = STROBE_ACTIVE;
        end else begin
          tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end

      ST_RESPAWN: begin
        // Out of lives: park here until GAMEOVER, no reload for the player.
        if (lives_q == 2'd0) begin
          state_d = ST_GAMEOVER;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RELOAD;
          fl_d    = STROBE_ACTIVE;
        end else begin
          hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end

      ST_RELOAD: begin
        state_d = ST_RUN;
      end

      ST_GAMEOVER, ST_WIN: begin
        if (!start_InLow) begin
          state_d = ST_START;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    over_d = (state_d == ST_GAMEOVER);
    won_d  = (state_d == ST_WIN);
  end

  // The prescaler only counts in RUN and restarts on every entry into RUN.
  assign run_next_s  = (state_d == ST_RUN);
  assign run_clear_s = (state_q != ST_RUN);

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge SC_PLAYER_STATEMACHINE_CLOCK_50 or
              posedge SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
    if (SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
      state_q <= ST_IDLE;
      level_q <= 2'd0;
      lives_q <= 2'd0;
      hold_q  <= {HOLD_W{1'b0}};
      tmo_q   <= {TMO_W{1'b0}};
      pl_q    <= STROBE_IDLE;
      fl_q    <= STROBE_IDLE;
      over_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      pl_q    <= pl_d;
      fl_q    <= fl_d;
      over_q  <= over_d;
      won_q   <= won_d;
    end
  end

  frogger_tick_prescaler #(
    .BASE_PERIOD (BASE_PERIOD)
  ) u_prescaler (
    .clk_i         (SC_PLAYER_STATEMACHINE_CLOCK_50),
    .rst_i         (SC_PLAYER_STATEMACHINE_RESET_InHigh),
    .level_i       (level_d),
    .enable_i      (run_next_s),
    .clear_i       (run_clear_s),
    .scroll_tick_o (scroll_tick)
  );

  assign PlayerLose_OutLow    = pl_q;
  assign FinishedLevel_OutLow = fl_q;
  assign level                = level_q;
  assign lives                = lives_q;
  assign game_over            = over_q;
  assign game_won             = won_q;

endmodule

// File: tb/tb_frogger_level_controller.sv
// -----------------------------------------------------------------------------
// tb_frogger_level_controller
// Directed stimulus with a phase/cycle-count model of the level sequencer.
// Inputs change just after the falling edge, the model advances on the rising
// edge, and every falling edge compares all outputs with the model. Directed
// literal checks pin lives/level/strobe and tick counts at key points.
// -----------------------------------------------------------------------------
module tb_frogger_level_controller;

  localparam int BASE   = 24;
  localparam int LIVES0 = 3;
  localparam int MAXL   = 3;
  localparam int HOLD   = 8;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_InLow = 1'b1;
  logic [7:0] player_row = 8'h00;
  logic [7:0] obstacle_row = 8'h00;
  logic       goal_InLow = 1'b1;
  logic       ack_InLow = 1'b1;
  logic       pl_o, fl_o, tick_o, over_o, won_o;
  logic [1:0] level_o, lives_o;

  frogger_level_controller dut (
    .SC_PLAYER_STATEMACHINE_CLOCK_50     (clk),
    .SC_PLAYER_STATEMACHINE_RESET_InHigh (rst),
    .start_InLow                         (start_InLow),
    .player_row                          (player_row),
    .obstacle_row                        (obstacle_row),
    .goal_InLow                          (goal_InLow),
    .player_lose_ack_InLow               (ack_InLow),
    .PlayerLose_OutLow                   (pl_o),
    .FinishedLevel_OutLow                (fl_o),
    .scroll_tick                         (tick_o),
    .level                               (level_o),
    .lives                               (lives_o),
    .game_over                           (over_o),
    .game_won                            (won_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pl_cnt = 0;
  int fl_cnt = 0;
  int tick_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- model: phase + cycles spent in it ----------------
  localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_HIT = 3, P_LVL = 4,
                 P_WAIT = 5, P_RESP = 6, P_RELOAD = 7, P_OVER = 8, P_WIN = 9;
  int m_phase, m_cnt, m_lives, m_level;

  task automatic model_reset();
    m_phase = P_IDLE; m_cnt = 0; m_lives = 0; m_level = 0;
  endtask

  task automatic enter(input int ph);
    m_phase = ph; m_cnt = 0;
  endtask

  task automatic model_step();
    if (rst) model_reset();
    else begin
      case (m_phase)
        P_IDLE:   if (!start_InLow) enter(P_START);
        P_START:  begin m_lives = LIVES0; m_level = 0; enter(P_RUN); end
        P_RUN:    if ((player_row & obstacle_row) != 8'h00) enter(P_HIT);
                  else if (!goal_InLow) enter(P_LVL);
                  else m_cnt++;
        P_HIT:    begin m_lives--; enter(P_WAIT); end
        P_LVL:    if (m_level == MAXL) enter(P_WIN);
                  else begin m_level++; enter(P_WAIT); end
        P_WAIT:   if (!ack_InLow) enter(P_RESP); else m_cnt++;
        P_RESP:   if (m_lives == 0) enter(P_OVER);
                  else if (m_cnt + 1 == HOLD) enter(P_RELOAD);
                  else m_cnt++;
        P_RELOAD: enter(P_RUN);
        P_OVER, P_WIN: if (!start_InLow) enter(P_START);
        default:  model_reset();
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    int per, e_tick, e_pl, e_fl;
    forever begin
      @(negedge clk);
      per    = BASE >> m_level;
      if (per == 0) per = 1;
      e_tick = (m_phase == P_RUN && (m_cnt % per) == per - 1) ? 1 : 0;
      e_pl   = ((m_phase == P_HIT) ||
                (m_phase == P_LVL && m_level < MAXL) ||
                (m_phase == P_WAIT && m_cnt > 0 && (m_cnt % TMO) == 0)) ? 0 : 1;
      e_fl   = (m_phase == P_RELOAD) ? 0 : 1;
      check("cyc_tick", tick_o, e_tick);
      check("cyc_pl", pl_o, e_pl);
      check("cyc_fl", fl_o, e_fl);
      check("cyc_level", level_o, m_level);
      check("cyc_lives", lives_o, m_lives);
      check("cyc_over", over_o, (m_phase == P_OVER) ? 1 : 0);
      check("cyc_won", won_o, (m_phase == P_WIN) ? 1 : 0);
      check("strobes_exclusive", (pl_o == 1'b0 && fl_o == 1'b0) ? 1 : 0, 0);
      if (pl_o == 1'b0) pl_cnt++;
      if (fl_o == 1'b0) fl_cnt++;
      if (tick_o == 1'b1) tick_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_InLow = 1'b0; cyc(1);
    start_InLow = 1'b1; cyc(1);
  endtask

  // One strobing event (hit and/or goal), ack two cycles into WAIT_ACK,
  // then ride out RESPAWN and RELOAD back into RUN.
  task automatic event_and_ack(input bit hit, input bit goal);
    if (hit) begin player_row = 8'h10; obstacle_row = 8'h10; end
    if (goal) goal_InLow = 1'b0;
    cyc(1);
    player_row = 8'h00; obstacle_row = 8'h00; goal_InLow = 1'b1;
    cyc(2);
    ack_InLow = 1'b0; cyc(1);
    ack_InLow = 1'b1; cyc(HOLD + 3);
  endtask

  initial begin
    int p0, f0, t0;
    cyc(3);
    check("rst_pl", pl_o, 1);
    check("rst_fl", fl_o, 1);
    check("rst_tick", tick_o, 0);
    check("rst_lives", lives_o, 0);
    check("rst_level", level_o, 0);
    rst = 1'b0;
    cyc(3);

    // Start: lives 3, level 0, tick every 24 clocks.
    pulse_start();
    check("start_lives", lives_o, 3);
    check("start_level", level_o, 0);
    t0 = tick_cnt; cyc(48);
    check("ticks_lvl0_48clk", tick_cnt - t0, 2);

    // Hit with ack two cycles later.
    p0 = pl_cnt; f0 = fl_cnt;
    event_and_ack(1'b1, 1'b0);
    check("hit_lives", lives_o, 2);
    check("hit_pl_pulses", pl_cnt - p0, 1);
    check("hit_fl_pulses", fl_cnt - f0, 1);

    // Goal at level 0 -> level 1, tick period 12.
    event_and_ack(1'b0, 1'b1);
    check("goal_level", level_o, 1);
    check("goal_lives", lives_o, 2);
    t0 = tick_cnt; cyc(24);
    check("ticks_lvl1_24clk", tick_cnt - t0, 2);

    // Collision and goal together: hit path wins.
    event_and_ack(1'b1, 1'b1);
    check("hitgoal_lives", lives_o, 1);
    check("hitgoal_level", level_o, 1);

    // Climb to level 3, then the final goal wins.
    event_and_ack(1'b0, 1'b1);
    event_and_ack(1'b0, 1'b1);
    check("climb_level", level_o, 3);
    p0 = pl_cnt;
    goal_InLow = 1'b0; cyc(1);
    goal_InLow = 1'b1; cyc(2);
    check("win_flag", won_o, 1);
    check("win_no_pl", pl_cnt - p0, 0);
    t0 = tick_cnt; cyc(30);
    check("win_no_ticks", tick_cnt - t0, 0);
    check("win_level", level_o, 3);

    // Restart, then lose all three lives.
    pulse_start();
    check("restart_lives", lives_o, 3);
    check("restart_level", level_o, 0);
    check("restart_won", won_o, 0);
    event_and_ack(1'b1, 1'b0);
    event_and_ack(1'b1, 1'b0);
    f0 = fl_cnt;
    player_row = 8'h01; obstacle_row = 8'h81; cyc(1);
    player_row = 8'h00; obstacle_row = 8'h00; cyc(2);
    ack_InLow = 1'b0; cyc(1);
    ack_InLow = 1'b1; cyc(3);
    check("over_flag", over_o, 1);
    check("over_lives", lives_o, 0);
    cyc(20);
    check("over_no_fl", fl_cnt - f0, 0);
    check("over_sticky", over_o, 1);
    pulse_start();
    check("over_restart_lives", lives_o, 3);
    check("over_restart_level", level_o, 0);
    check("over_restart_flag", over_o, 0);

    // Unloaded player row never collides.
    p0 = pl_cnt;
    player_row = 8'h00; obstacle_row = 8'hFF; cyc(3);
    obstacle_row = 8'h00;
    check("empty_row_no_hit", pl_cnt - p0, 0);

    // Ack withheld: PlayerLose is re-sent after 16 clocks.
    p0 = pl_cnt;
    player_row = 8'h04; obstacle_row = 8'h04; cyc(1);
    player_row = 8'h00; obstacle_row = 8'h00; cyc(20);
    check("timeout_pl_pulses", pl_cnt - p0, 2);

    // Reset in the middle of WAIT_ACK acts immediately.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_pl", pl_o, 1);
    check("arst_fl", fl_o, 1);
    check("arst_tick", tick_o, 0);
    check("arst_lives", lives_o, 0);
    check("arst_level", level_o, 0);
    check("arst_over", over_o, 0);
    check("arst_won", won_o, 0);
    cyc(3);
    rst = 1'b0;
    p0 = pl_cnt; f0 = fl_cnt;
    ack_InLow = 1'b0; cyc(20);
    ack_InLow = 1'b1; cyc(2);
    check("post_rst_no_pl", pl_cnt - p0, 0);
    check("post_rst_no_fl", fl_cnt - f0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frogger_level_controller.md
Name: frogger_level_controller

Overview:
- Game-level sequencer that drives the player state machine. Compares the player row against the active obstacle row and counts lives and levels.
- Generates the obstacle-scroll tick, whose speed depends on the current level.
- Issues the active-low PlayerLose / FinishedLevel strobes that force the player FSM through its lose -> load-player sequence.
- Sits between the player FSM, the obstacle row registers and the top-level display.

Parameters:
- BASE_PERIOD, 24, scroll-tick period in clocks at level 0; period at level L = BASE_PERIOD >> L.
- START_LIVES, 3, lives loaded on game start (1..3).
- MAX_LEVEL, 3, highest level index; finishing this level wins the game.
- RESPAWN_HOLD, 8, clocks spent in RESPAWN before the reload strobe (>=1).

Ports:
- SC_PLAYER_STATEMACHINE_CLOCK_50  in  1  system clock.
- SC_PLAYER_STATEMACHINE_RESET_InHigh  in  1  asynchronous, active-high reset.
- start_InLow  in  1  start button, already synchronised and debounced.
- player_row  in  8  one-hot player position, from the player shift register.
- obstacle_row  in  8  obstacle bits on the player's row (1 = obstacle).
- goal_InLow  in  1  low = player reached the goal row.
- player_lose_ack_InLow  in  1  player FSM PlayerLose output (low while in its lose state).
- PlayerLose_OutLow  out  1  to player FSM PlayerLose input; one-cycle low strobe.
- FinishedLevel_OutLow  out  1  to player FSM FinishedLevel input; one-cycle low strobe.
- scroll_tick  out  1  one-cycle obstacle-shift enable.
- level  out  2  current level.
- lives  out  2  remaining lives.
- game_over  out  1  high in GAMEOVER.
- game_won  out  1  high in WIN.

Behaviour:
- Reset (async): state IDLE, level=0, lives=0, prescaler=0, PlayerLose_OutLow=1, FinishedLevel_OutLow=1, scroll_tick=0, game_over=0, game_won=0.
- States: IDLE, START, RUN, HIT, LEVELUP, WAIT_ACK, RESPAWN, RELOAD, GAMEOVER, WIN.
- IDLE: start_InLow==0 -> START.
- START (1 cycle): lives<=START_LIVES, level<=0, prescaler<=0; -> RUN.
- RUN behaviour:
  - Prescaler counts 0..(BASE_PERIOD>>level)-1; scroll_tick=1 for the single cycle in which it wraps.
  - hit = |(player_row & obstacle_row), evaluated every cycle.
  - hit -> HIT, which takes priority over goal.
  - Else goal_InLow==0 -> LEVELUP.
- HIT (1 cycle): lives<=lives-1. PlayerLose_OutLow=0 this cycle. -> WAIT_ACK.
- LEVELUP (1 cycle):
  - If level==MAX_LEVEL -> WIN; level is unchanged.
  - Else level<=level+1, prescaler<=0, PlayerLose_OutLow=0 this cycle, -> WAIT_ACK.
- WAIT_ACK: hold PlayerLose_OutLow=1; wait for player_lose_ack_InLow==0, then -> RESPAWN and clear the hold counter.
  - Timeout: 16 clocks without ack -> re-pulse PlayerLose_OutLow for 1 cycle, restart the timeout.
- RESPAWN: count RESPAWN_HOLD clocks, no scroll ticks.
  - lives==0 at entry -> GAMEOVER; the player FSM is left in its lose state.
  - Else, after RESPAWN_HOLD clocks -> RELOAD.
- RELOAD (1 cycle): FinishedLevel_OutLow=0. -> RUN with prescaler=0.
- GAMEOVER, WIN: sticky. game_over or game_won=1, no ticks. start_InLow==0 -> START.
- Strobes are registered outputs, low exactly in the clock following entry to the strobing state. They are never low simultaneously.
- lives never underflows: HIT is only reachable with lives>=1.
- scroll_tick is 0 in every state except RUN.
- Collision with player_row==0 (player row unloaded) is not a hit.
- Reset mid-sequence, e.g. during WAIT_ACK: everything returns to IDLE immediately. No strobe is emitted after reset release until START.
- Width rules:
  - Prescaler width is clog2(BASE_PERIOD).
  - Period is BASE_PERIOD>>level, with a minimum of 1.
  - level is 2 bits unsigned, saturating at MAX_LEVEL.

Decomposition:
- Shared package: state encoding constants, the strobe polarity constants, and the WAIT_ACK timeout (16).
- One sub-module, frogger_tick_prescaler:
  - Inputs: level, clear, enable.
  - Output: scroll_tick.
  - Counts to BASE_PERIOD>>level and wraps.
- The FSM, lives/level counters and hold counter stay in the top block.

Test Plan:
- Reset then start_InLow low 1 cycle -> START then RUN; lives=3, level=0; scroll_tick pulses every 24 clocks.
- In RUN, player_row=8'h10, obstacle_row=8'h10 -> HIT. PlayerLose_OutLow low 1 cycle, lives=2. Ack low 2 cycles later -> RESPAWN 8 clocks -> FinishedLevel_OutLow low 1 cycle -> RUN.
- goal_InLow low at level 0 -> level=1, reload sequence; scroll_tick period becomes 12. At level 3 a goal -> WIN, game_won=1, no ticks.
- Collision and goal in the same cycle -> HIT path taken, level unchanged, lives decremented.
- Three successive hits -> lives=0; after the third ack -> GAMEOVER, game_over=1, FinishedLevel_OutLow never strobes. start_InLow low -> lives=3, level=0.
- Ack withheld 16 clocks in WAIT_ACK -> second PlayerLose_OutLow pulse; assert reset mid-WAIT_ACK -> all outputs at reset values asynchronously, state IDLE.
